// File: rtl/music_pkg.sv
// Purpose : shared types and constants for the tape note sequencer.
// Latency : n/a (types, constants and one pure function).
// Backpressure: n/a.
package music_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROW,
    PLAY,
    GAP,
    ADVANCE,
    STOP
  } state_e;

  // Duration code in tape_bits[1:0]: right-shift applied to one second.
  typedef enum logic [1:0] {
    DUR_WHOLE   = 2'd0,
    DUR_HALF    = 2'd1,
    DUR_QUARTER = 2'd2,
    DUR_EIGHTH  = 2'd3
  } dur_e;

  localparam logic [5:0] END_NOTE  = 6'h3F;
  localparam logic [5:0] REST_NOTE = 6'd0;
  localparam int         DUR_CNT_W = 27;

  function automatic logic [DUR_CNT_W-1:0] note_ticks(
    input logic [DUR_CNT_W-1:0] ticks_per_sec,
    input dur_e                 dur
  );
    return ticks_per_sec >> dur;
  endfunction

endpackage

// File: rtl/row_debouncer.sv
// Purpose : 2-FF synchronizer plus stability counter for the sprocket-hole sensor.
// Latency : row_db follows row_valid 2 + DEBOUNCE_TICKS cycles after it settles.
// Backpressure: none; free-running filter.
// Ports   : clk, rst_n (async active-low), row_valid (raw, async), row_db (filtered).
module row_debouncer #(
  parameter int unsigned DEBOUNCE_TICKS = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic row_valid,
  output logic row_db
);

  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          row_db_q, row_db_d;

  always_comb begin
    sync_d   = {sync_q[0], row_valid};
    row_db_d = row_db_q;
    cnt_d    = '0;
    // Count consecutive cycles of disagreement; any agreement restarts it.
    if (sync_q[1] != row_db_q) begin
      if (cnt_q == CNT_LAST) begin
        row_db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      row_db_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      row_db_q <= row_db_d;
    end
  end

  assign row_db = row_db_q;

endmodule

// File: rtl/tape_note_sequencer.sv
// Purpose : reads note rows off a punched tape and times each note for the player.
// Latency : registered outputs; inputs add 2-FF sync (row also adds debounce) delay.
// Backpressure: none; the player consumes incode continuously.
// Ports   : clk, rst_n, play, row_valid, tape_bits[7:0] in; incode[7:0], motor_en, done, tape_err out.
module tape_note_sequencer
  import music_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC  = 100_000_000,
  parameter int unsigned GAP_TICKS      = 1_000_000,
  parameter int unsigned DEBOUNCE_TICKS = 100_000,
  parameter int unsigned TIMEOUT_TICKS  = 200_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play,
  input  logic       row_valid,
  input  logic [7:0] tape_bits,
  output logic [7:0] incode,
  output logic       motor_en,
  output logic       done,
  output logic       tape_err
);

  if (TICKS_PER_SEC / 8 <= GAP_TICKS) begin : g_bad_params
    $error("tape_note_sequencer: TICKS_PER_SEC/8 must exceed GAP_TICKS");
  end

  localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [DUR_CNT_W-1:0] TPS_W    = DUR_CNT_W'(TICKS_PER_SEC);
  localparam logic [DUR_CNT_W-1:0] GAP_W    = DUR_CNT_W'(GAP_TICKS);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);

  logic                 play_meta_q, play_meta_d, play_s_q, play_s_d;
  logic [7:0]           tape_meta_q, tape_meta_d, tape_s_q, tape_s_d;
  logic                 row_db, row_prev_q, row_prev_d, row_rise;
  state_e               state_q, state_d;
  logic [7:0]           code_q, code_d;
  logic [DUR_CNT_W-1:0] dur_cnt_q, dur_cnt_d, play_len;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [7:0]           incode_q, incode_d;
  logic                 motor_q, motor_d, done_q, done_d, err_q, err_d;

  row_debouncer #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_row_debouncer (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_valid (row_valid),
    .row_db    (row_db)
  );

  always_comb begin
    play_meta_d = play;
    play_s_d    = play_meta_q;
    tape_meta_d = tape_bits;
    tape_s_d    = tape_meta_q;
    row_prev_d  = row_db;
  end

  assign row_rise = row_db & ~row_prev_q;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    dur_cnt_d = '0;
    tmo_cnt_d = '0;
    done_d    = done_q;
    err_d     = err_q;
    // Audible part of the note; the rest of its slot is the GAP.
    play_len  = note_ticks(TPS_W, dur_e'(code_q[1:0])) - GAP_W;

    case (state_q)
      IDLE: begin
        code_d = {REST_NOTE, 2'b00};
        if (play_s_q) state_d = WAIT_ROW;
      end
      WAIT_ROW: begin
        if (!play_s_q) begin
          state_d = IDLE;
          code_d  = {REST_NOTE, 2'b00};
        end else if (row_rise) begin
          code_d = tape_s_q;
          if (tape_s_q[7:2] == END_NOTE) begin
            state_d = STOP;
            done_d  = 1'b1;
          end else begin
            state_d = PLAY;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = STOP;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      PLAY: begin
        if (!play_s_q) begin
          state_d = IDLE;
          code_d  = {REST_NOTE, 2'b00};
        end else if (dur_cnt_q == play_len - DUR_CNT_W'(1)) begin
          state_d = GAP;
        end else begin
          dur_cnt_d = dur_cnt_q + DUR_CNT_W'(1);
        end
      end
      GAP: begin
        if (!play_s_q) begin
          state_d = IDLE;
          code_d  = {REST_NOTE, 2'b00};
        end else if (dur_cnt_q == GAP_W - DUR_CNT_W'(1)) begin
          state_d = ADVANCE;
        end else begin
          dur_cnt_d = dur_cnt_q + DUR_CNT_W'(1);
        end
      end
      ADVANCE: begin
        // Feed until the current hole has passed the sensor.
        if (!play_s_q) begin
          state_d = IDLE;
          code_d  = {REST_NOTE, 2'b00};
        end else if (!row_db) begin
          state_d = WAIT_ROW;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = STOP;
          err_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      STOP: begin
        if (!play_s_q) begin
          state_d = IDLE;
          code_d  = {REST_NOTE, 2'b00};
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    incode_d = 8'd0;
    if (state_d == PLAY)     incode_d = code_d;
    else if (state_d == GAP) incode_d = {6'd0, code_d[1:0]};
    motor_d = (state_d == WAIT_ROW) || (state_d == ADVANCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      play_meta_q <= 1'b0;
      play_s_q    <= 1'b0;
      tape_meta_q <= '0;
      tape_s_q    <= '0;
      row_prev_q  <= 1'b0;
      state_q     <= IDLE;
      code_q      <= '0;
      dur_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      incode_q    <= '0;
      motor_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      play_meta_q <= play_meta_d;
      play_s_q    <= play_s_d;
      tape_meta_q <= tape_meta_d;
      tape_s_q    <= tape_s_d;
      row_prev_q  <= row_prev_d;
      state_q     <= state_d;
      code_q      <= code_d;
      dur_cnt_q   <= dur_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      incode_q    <= incode_d;
      motor_q     <= motor_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign incode   = incode_q;
  assign motor_en = motor_q;
  assign done     = done_q;
  assign tape_err = err_q;

endmodule

// File: tb/tb_tape_note_sequencer.sv
// Purpose : self-checking bench for tape_note_sequencer with a segment scoreboard.
// Latency : n/a.
// Backpressure: n/a.
module tb_tape_note_sequencer;

  localparam int TPS = 800;
  localparam int GAP_T = 10;
  localparam int DEB = 4;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       rst_n, play, row_valid;
  logic [7:0] tape_bits, incode;
  logic       motor_en, done, tape_err;

  always #5 clk = ~clk;

  tape_note_sequencer #(
    .TICKS_PER_SEC  (TPS),
    .GAP_TICKS      (GAP_T),
    .DEBOUNCE_TICKS (DEB),
    .TIMEOUT_TICKS  (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .play      (play),
    .row_valid (row_valid),
    .tape_bits (tape_bits),
    .incode    (incode),
    .motor_en  (motor_en),
    .done      (done),
    .tape_err  (tape_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] code;
    int         len;
  } seg_t;
  seg_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    play      = 1'b0;
    row_valid = 1'b0;
    tape_bits = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Expected incode runs for one note: audible part then the gap code.
  task automatic push_note(input logic [7:0] code);
    int   full;
    seg_t s;
    full = TPS >> code[1:0];
    if (code[7:2] == 6'd0) begin
      s.code = code; s.len = full; exp_q.push_back(s);
    end else begin
      s.code = code; s.len = full - GAP_T; exp_q.push_back(s);
      if (code[1:0] != 2'd0) begin
        s.code = {6'd0, code[1:0]}; s.len = GAP_T; exp_q.push_back(s);
      end
    end
  endtask

  task automatic feed_row(input logic [7:0] b);
    @(posedge clk);
    #1 row_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 tape_bits = b;
    row_valid = 1'b1;
  endtask

  task automatic collect(input int nseg);
    int         waited;
    int         len;
    logic [7:0] v;
    seg_t       e;
    waited = 0;
    @(negedge clk);
    while (incode == 8'd0 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("note_start", (incode != 8'd0), 1'b1);
    for (int i = 0; i < nseg; i++) begin
      v   = incode;
      len = 0;
      while (incode == v && len < 2000) begin
        len++;
        @(negedge clk);
      end
      check("sb_depth", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin e.code = 8'h00; e.len = 0; end
      check("seg_code", v, e.code);
      check("seg_len", len, e.len);
    end
    check("adv_motor", motor_en, 1'b1);
    check("adv_incode", incode, 8'd0);
  endtask

  initial begin
    int w;
    do_reset();
    @(negedge clk);
    check("rst_incode", incode, 8'd0);
    check("rst_motor", motor_en, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", tape_err, 1'b0);

    // Steady row, then a sequence of further rows including a rest note.
    @(posedge clk);
    #1 play = 1'b1;
    tape_bits = 8'b000101_10;
    row_valid = 1'b1;
    push_note(8'b000101_10);
    collect(2);
    feed_row(8'b000111_01);
    push_note(8'b000111_01);
    collect(2);
    feed_row(8'b000001_11);
    push_note(8'b000001_11);
    collect(2);
    feed_row(8'b000000_11);
    push_note(8'b000000_11);
    collect(1);
    check("s1_done", done, 1'b0);
    check("s1_err", tape_err, 1'b0);

    // Short glitch on the sensor must be filtered out.
    do_reset();
    play = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("s2_motor_pre", motor_en, 1'b1);
    @(posedge clk);
    #1 row_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 row_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("s2_motor", motor_en, 1'b1);
      check("s2_incode", incode, 8'd0);
    end

    // End-of-tape marker.
    do_reset();
    play = 1'b1;
    tape_bits = 8'hFC;
    row_valid = 1'b1;
    w = 0;
    while (!done && w < 300) begin @(negedge clk); w++; end
    check("s3_done", done, 1'b1);
    check("s3_incode", incode, 8'd0);
    check("s3_motor", motor_en, 1'b0);
    check("s3_err", tape_err, 1'b0);
    play = 1'b0;
    repeat (4) @(negedge clk);
    check("s3_done_clr", done, 1'b0);
    check("s3_idle_motor", motor_en, 1'b0);
    check("s3_idle_incode", incode, 8'd0);

    // No row ever arrives: timeout.
    do_reset();
    play = 1'b1;
    w = 0;
    while (!tape_err && w < 2100) begin @(negedge clk); w++; end
    check("s4_err", tape_err, 1'b1);
    check("s4_window", (w >= 2000 && w <= 2010), 1'b1);
    check("s4_motor", motor_en, 1'b0);
    check("s4_done", done, 1'b0);

    // Pause mid-note.
    do_reset();
    play = 1'b1;
    tape_bits = 8'b001111_00;
    row_valid = 1'b1;
    w = 0;
    while (incode == 8'd0 && w < 300) begin @(negedge clk); w++; end
    w = 0;
    while (incode == 8'h3C && w < 100) begin w++; @(negedge clk); end
    check("s5_run100", w, 100);
    play = 1'b0;
    @(negedge clk);
    check("s5_hold1", incode, 8'h3C);
    @(negedge clk);
    check("s5_hold2", incode, 8'h3C);
    @(negedge clk);
    check("s5_off", incode, 8'd0);
    check("s5_off_motor", motor_en, 1'b0);
    repeat (3) @(negedge clk);
    check("s5_idle_motor", motor_en, 1'b0);
    // Resuming must not replay the discarded note: row_db is already high.
    play = 1'b1;
    repeat (4) @(negedge clk);
    check("s5_resume_incode", incode, 8'd0);
    check("s5_resume_motor", motor_en, 1'b1);

    // Asynchronous reset mid-note.
    do_reset();
    play = 1'b1;
    tape_bits = 8'b000101_10;
    row_valid = 1'b1;
    w = 0;
    while (incode == 8'd0 && w < 300) begin @(negedge clk); w++; end
    check("s6_playing", incode, 8'h16);
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("s6_async_incode", incode, 8'd0);
    check("s6_async_motor", motor_en, 1'b0);
    repeat (2) @(negedge clk);
    check("s6_held_incode", incode, 8'd0);
    rst_n = 1'b1;

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tape_note_sequencer.md
TAPE_NOTE_SEQUENCER -- requirements
Module: tape_note_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100_000_000: clock ticks per one-second note.
REQ-002 SHALL have parameter GAP_TICKS, default 1_000_000: rest between notes, in ticks.
REQ-003 SHALL have parameter DEBOUNCE_TICKS, default 100_000: cycles the row strobe must be stable.
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 200_000_000: maximum time in WAIT_ROW before a tape error.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port play, input, 1 bit: run/pause level from the user switch; asynchronous.
REQ-008 SHALL have port row_valid, input, 1 bit: raw sprocket-hole sensor; asynchronous and bouncy.
REQ-009 SHALL have port tape_bits, input, 8 bits: raw hole row; [7:2] = note index, [1:0] = duration code.
REQ-010 SHALL have port incode, output, 8 bits: note/duration code to the music player.
REQ-011 SHALL have port motor_en, output, 1 bit: tape feed motor enable.
REQ-012 SHALL have port done, output, 1 bit: end-of-tape marker reached.
REQ-013 SHALL have port tape_err, output, 1 bit: row timeout occurred.

Function
REQ-014 play, row_valid and tape_bits SHALL each pass through a 2-FF synchronizer.
REQ-015 Debounced row (row_db) SHALL change state only after the synchronized row_valid has differed from row_db for DEBOUNCE_TICKS consecutive cycles; a shorter pulse SHALL be ignored.
REQ-016 On the cycle row_db rises in WAIT_ROW, synchronized tape_bits SHALL be latched into code_q.
REQ-017 Duration SHALL be TICKS_PER_SEC >> code_q[1:0] (1, 1/2, 1/4, 1/8 s); the counter SHALL be 27 bits.
REQ-018 The FSM SHALL have states IDLE, WAIT_ROW, PLAY, GAP, ADVANCE, STOP.
REQ-019 IDLE: incode=0, motor_en=0; when play=1, go to WAIT_ROW next cycle.
REQ-020 WAIT_ROW: motor_en=1, incode=0, timeout counter runs; on row_db rising edge, latch the row, stop the motor and clear the timeout counter.
REQ-021 From WAIT_ROW, latched note field 6'h3F SHALL go to STOP with done=1; any other value SHALL go to PLAY.
REQ-022 PLAY: incode=code_q for exactly duration minus GAP_TICKS cycles, starting the cycle after the latch; motor_en=0.
REQ-023 GAP: incode={6'd0, code_q[1:0]} for exactly GAP_TICKS cycles, then ADVANCE.
REQ-024 ADVANCE: motor_en=1, incode=0; on row_db low go to WAIT_ROW; if row_db is already low, go to WAIT_ROW the next cycle.
REQ-025 TIMEOUT_TICKS cycles in WAIT_ROW or ADVANCE without progress SHALL go to STOP with tape_err=1.
REQ-026 STOP: incode=0, motor_en=0, done/tape_err held; on play=0, clear the flags and go to IDLE.
REQ-027 play=0 in WAIT_ROW, PLAY, GAP or ADVANCE SHALL go to IDLE on the next cycle, with incode=0 and motor_en=0; code_q is discarded.
REQ-028 Note index 0 SHALL be played as a timed rest (incode passes through; the player outputs silence).
REQ-029 Parameters SHALL satisfy TICKS_PER_SEC/8 > GAP_TICKS; this is checked at elaboration.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst_n=0 SHALL asynchronously force IDLE, incode=0, motor_en=0, done=0, tape_err=0, code_q=0, all counters 0, and synchronizers and row_db to 0.
REQ-032 Reset asserted mid-note SHALL silence incode immediately, with no completion of the GAP.

Structure
REQ-033 Shared package music_pkg SHALL hold: the state enum, END_NOTE=6'h3F, the duration-shift encoding, and REST_NOTE=6'd0.
REQ-034 One sub-module, row_debouncer (synchronizer + stability counter, parameter DEBOUNCE_TICKS), SHALL produce row_db.

Verification
Bench parameters: TICKS_PER_SEC=800, GAP_TICKS=10, DEBOUNCE_TICKS=4, TIMEOUT_TICKS=2000.
REQ-035 Scenario: play=1, row 8'b000101_10 held steady -> incode=8'h16 for 190 cycles, then 8'h02 for 10 cycles, then motor_en=1.
REQ-036 Scenario: row_valid pulses high for 3 cycles in WAIT_ROW -> ignored, motor_en stays 1, incode=0.
REQ-037 Scenario: row 8'hFC -> STOP, done=1, incode=0, motor_en=0; play=0 -> IDLE, done=0.
REQ-038 Scenario: no row_valid for 2000 cycles -> tape_err=1, motor_en=0.
REQ-039 Scenario: row 8'b001111_00 -> incode=8'h3C for 790 cycles; play=0 at cycle 100 -> next cycle incode=0, state IDLE.
REQ-040 Scenario: rst_n=0 mid-PLAY -> incode=0 and motor_en=0 without waiting for a clock edge.
